fas: RTL and testbench

FAS -- requirements
Module: fas

---
 rtl/fas.sv | 71 +++++++
 tb/tb_fas.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fas.sv
// rtl/fas.sv - single-bit add/subtract cell with registered outputs and carry toggle counter
//
// Purpose:
//    One bit slice of a ripple adder/subtractor. In subtract mode the B operand
//    is inverted and the caller drives cin=1 on the LSB, so cout=1 means no borrow.
//    The combinational sum/carry are also registered, and the number of clock
//    edges on which the registered carry changed value is counted (saturating).
//
// Ports:
//    clk           in   1  clock, all state updates on rising edge
//    rst           in   1  synchronous active-high reset
//    a             in   1  operand A bit
//    b             in   1  operand B bit
//    cin           in   1  carry-in (borrow-chain carry in subtract mode)
//    a_ns          in   1  mode: 1 = add, 0 = subtract
//    s             out  1  combinational sum/difference bit
//    cout          out  1  combinational carry-out
//    s_q           out  1  registered s
//    cout_q        out  1  registered cout
//    cout_tgl_cnt  out  8  saturating count of registered-cout changes

module fas (
   input  logic       clk,
   input  logic       rst,
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic       a_ns,
   output logic       s,
   output logic       cout,
   output logic       s_q,
   output logic       cout_q,
   output logic [7:0] cout_tgl_cnt
);

   logic       w_bb;
   logic       w_p;
   logic       w_tgl;
   logic       r_s_q;
   logic       r_cout_q;
   logic [7:0] r_cnt;

   // Subtract is a + ~b + cin; the inversion happens here so the adder is shared.
   assign w_bb = a_ns ? b : ~b;
   assign w_p  = a ^ w_bb;
   assign s    = w_p ^ cin;
   assign cout = (a & w_bb) | (cin & w_p);

   // A toggle is judged against the value about to be replaced, so the first
   // load after reset counts when cout=1 (cout_q is 0 coming out of reset).
   assign w_tgl = (cout != r_cout_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_q    <= 1'b0;
         r_cout_q <= 1'b0;
         r_cnt    <= 8'd0;
      end else begin
         r_s_q    <= s;
         r_cout_q <= cout;
         if (w_tgl && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign s_q          = r_s_q;
   assign cout_q       = r_cout_q;
   assign cout_tgl_cnt = r_cnt;

endmodule

// File: tb/tb_fas.sv
// tb/tb_fas.sv - self-checking bench for fas
//
// Purpose:
//    Table-driven exhaustive sweep, hand sequences for cin walks, mid-run reset
//    and counter saturation, then randomized stimulus against an arithmetic model.
//
// Ports:
//    none (top-level bench)

module tb_fas;

   logic       clk;
   logic       rst;
   logic       a;
   logic       b;
   logic       cin;
   logic       a_ns;
   logic       s;
   logic       cout;
   logic       s_q;
   logic       cout_q;
   logic [7:0] cout_tgl_cnt;

   int n_tests;
   int n_fail;

   // reference state
   bit m_sq;
   bit m_cq;
   int m_cnt;

   typedef struct {
      bit a;
      bit b;
      bit cin;
      bit a_ns;
      bit exp_s;
      bit exp_cout;
   } vec_t;

   vec_t vecs[16];

   fas dut (
      .clk          (clk),
      .rst          (rst),
      .a            (a),
      .b            (b),
      .cin          (cin),
      .a_ns         (a_ns),
      .s            (s),
      .cout         (cout),
      .s_q          (s_q),
      .cout_q       (cout_q),
      .cout_tgl_cnt (cout_tgl_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-level result from integer arithmetic: a + (b or 1-b) + cin.
   function automatic bit [1:0] ref_sum(input bit fa, input bit fb, input bit fc, input bit fm);
      int bb;
      int sum;
      bb  = fm ? int'(fb) : 1 - int'(fb);
      sum = int'(fa) + bb + int'(fc);
      ref_sum = {sum >= 2, (sum % 2) == 1};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit ta, input bit tb, input bit tc, input bit tm, input bit tr);
      a    = ta;
      b    = tb;
      cin  = tc;
      a_ns = tm;
      rst  = tr;
   endtask

   // Advance one edge, update the reference from the inputs held at that edge,
   // then compare the registered outputs just after it.
   task automatic tick();
      bit [1:0] r;
      @(posedge clk);
      r = ref_sum(a, b, cin, a_ns);
      if (rst) begin
         m_sq  = 1'b0;
         m_cq  = 1'b0;
         m_cnt = 0;
      end else begin
         if ((r[1] != m_cq) && (m_cnt < 255)) m_cnt++;
         m_sq = r[0];
         m_cq = r[1];
      end
      #1;
      chk("s_q", 8'(s_q), 8'(m_sq));
      chk("cout_q", 8'(cout_q), 8'(m_cq));
      chk("cout_tgl_cnt", cout_tgl_cnt, 8'(m_cnt));
   endtask

   task automatic chk_comb(input string name);
      bit [1:0] r;
      r = ref_sum(a, b, cin, a_ns);
      chk({name, ".s"}, 8'(s), 8'(r[0]));
      chk({name, ".cout"}, 8'(cout), 8'(r[1]));
   endtask

   initial begin
      bit [2:0] walk[5];
      bit       walk_add0;
      n_tests = 0;
      n_fail  = 0;
      m_sq    = 1'b0;
      m_cq    = 1'b0;
      m_cnt   = 0;

      // {a,b,cin,a_ns,exp_s,exp_cout}
      vecs[0]  = '{0,0,0,1, 0,0};
      vecs[1]  = '{0,0,1,1, 1,0};
      vecs[2]  = '{0,1,0,1, 1,0};
      vecs[3]  = '{0,1,1,1, 0,1};
      vecs[4]  = '{1,0,0,1, 1,0};
      vecs[5]  = '{1,0,1,1, 0,1};
      vecs[6]  = '{1,1,0,1, 0,1};
      vecs[7]  = '{1,1,1,1, 1,1};
      vecs[8]  = '{0,0,0,0, 1,0};
      vecs[9]  = '{0,0,1,0, 0,1};
      vecs[10] = '{0,1,0,0, 0,0};
      vecs[11] = '{0,1,1,0, 1,0};
      vecs[12] = '{1,0,0,0, 0,1};
      vecs[13] = '{1,0,1,0, 1,1};
      vecs[14] = '{1,1,0,0, 1,0};
      vecs[15] = '{1,1,1,0, 0,1};

      // Reset state; comb outputs still follow inputs while in reset.
      drive(1, 1, 0, 1, 1);
      tick();
      chk("reset.s_q", 8'(s_q), 8'd0);
      chk("reset.cout_q", 8'(cout_q), 8'd0);
      chk("reset.cnt", cout_tgl_cnt, 8'd0);
      chk("reset.cout_live", 8'(cout), 8'd1);
      chk("reset.s_live", 8'(s), 8'd0);

      // Exhaustive sweep from the table.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].a_ns, 0);
         #1;
         chk($sformatf("vec%0d.s", i), 8'(s), 8'(vecs[i].exp_s));
         chk($sformatf("vec%0d.cout", i), 8'(cout), 8'(vecs[i].exp_cout));
         chk($sformatf("vec%0d.s_q_held", i), 8'(s_q), 8'(m_sq));
         tick();
         chk($sformatf("vec%0d.s_q", i), 8'(s_q), 8'(vecs[i].exp_s));
         chk($sformatf("vec%0d.cout_q", i), 8'(cout_q), 8'(vecs[i].exp_cout));
      end

      // cin walks 0->1->0 on the propagate cases; {a,b,a_ns}
      walk[0] = 3'b001;
      walk[1] = 3'b000;
      walk[2] = 3'b101;
      walk[3] = 3'b011;
      walk[4] = 3'b110;
      for (int k = 0; k < 5; k++) begin
         walk_add0 = (k == 0);
         for (int j = 0; j < 3; j++) begin
            bit c;
            c = (j == 1);
            drive(walk[k][2], walk[k][1], c, walk[k][0], 0);
            #1;
            // add with a=b=0: carry stuck at 0; all others: carry follows cin, s = ~cin
            chk($sformatf("walk%0d.%0d.cout", k, j), 8'(cout), walk_add0 ? 8'd0 : 8'(c));
            chk($sformatf("walk%0d.%0d.s", k, j), 8'(s), walk_add0 ? 8'(c) : 8'(!c));
            tick();
         end
      end

      // Mid-sequence reset with cout=1, then first load after reset counts.
      drive(1, 1, 0, 1, 0);
      tick();
      drive(1, 1, 0, 1, 1);
      tick();
      chk("midrst.s_q", 8'(s_q), 8'd0);
      chk("midrst.cout_q", 8'(cout_q), 8'd0);
      chk("midrst.cnt", cout_tgl_cnt, 8'd0);
      chk("midrst.cout", 8'(cout), 8'd1);
      chk("midrst.s", 8'(s), 8'd0);
      drive(1, 1, 0, 1, 0);
      tick();
      chk("post_rst.cout_q", 8'(cout_q), 8'd1);
      chk("post_rst.cnt", cout_tgl_cnt, 8'd1);

      // Saturation: cout = cin in subtract mode with a=b=0.
      drive(0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 300; i++) begin
         drive(0, 0, (i % 2) == 0, 0, 0);
         tick();
         if (i == 254) chk("sat.at255", cout_tgl_cnt, 8'd255);
      end
      chk("sat.hold", cout_tgl_cnt, 8'd255);

      // Random stimulus with occasional reset.
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
         #1;
         chk_comb("rand");
         chk("rand.s_q_held", 8'(s_q), 8'(m_sq));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
